// File: rtl/dec_stream_if.sv
// Stream bundle for dec_stream: encoded words in, decoded words plus per-lane
// error flags out, each side with its own valid/ready handshake.
interface dec_stream_if #(
  parameter int N = 8
);
  logic [N-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   out_data;
  logic [N/2-1:0] out_err;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );
endinterface

// File: rtl/dec_stream.sv
// Streaming 2-bit-per-symbol decoder with a two-entry skid buffer, per-lane
// illegal-symbol flags and a saturating errored-word counter.
module dec_stream #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  dec_stream_if.slave   bus,
  input  logic          err_clr,
  output logic [CW-1:0] err_cnt,
  output logic          err_sticky
);
  localparam int L = N / 2;

  logic [N-1:0] dec_data;
  logic [L-1:0] dec_err;
  logic [N-1:0] m_data, s_data;
  logic [L-1:0] m_err, s_err;
  logic         m_valid, s_valid, ready_q;
  logic         accept, drain, s_valid_next, err_word;

  // Only the code 11 is illegal; it passes through as 11 with its lane flagged.
  always_comb begin
    dec_data = '0;
    dec_err  = '0;
    for (int k = 0; k < L; k++) begin
      case (bus.in_data[2*k +: 2])
        2'b10:   dec_data[2*k +: 2] = 2'b00;
        2'b01:   dec_data[2*k +: 2] = 2'b01;
        2'b00:   dec_data[2*k +: 2] = 2'b10;
        default: begin
          dec_data[2*k +: 2] = 2'b11;
          dec_err[k]         = 1'b1;
        end
      endcase
    end
  end

  assign accept   = bus.in_valid && ready_q;
  assign drain    = m_valid && bus.out_ready;
  assign err_word = accept && (dec_err != '0);

  // A word lands in S only while M is stalled; S empties whenever M drains.
  assign s_valid_next = s_valid ? !drain : (accept && m_valid && !drain);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      ready_q <= 1'b1;
      m_data  <= '0;
      m_err   <= '0;
      s_data  <= '0;
      s_err   <= '0;
    end else begin
      if (drain) begin
        if (s_valid) begin
          m_data <= s_data;
          m_err  <= s_err;
        end else if (accept) begin
          m_data <= dec_data;
          m_err  <= dec_err;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (!m_valid) begin
        if (accept) begin
          m_valid <= 1'b1;
          m_data  <= dec_data;
          m_err   <= dec_err;
        end
      end else if (accept) begin
        s_data <= dec_data;
        s_err  <= dec_err;
      end
      s_valid <= s_valid_next;
      ready_q <= !s_valid_next;
    end
  end

  // Clear takes effect before a same-cycle increment, so clear+error yields 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (err_clr) begin
      err_cnt    <= err_word ? {{(CW-1){1'b0}}, 1'b1} : '0;
      err_sticky <= err_word;
    end else if (err_word) begin
      err_sticky <= 1'b1;
      if (err_cnt != {CW{1'b1}})
        err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = m_valid;
  assign bus.out_data  = m_data;
  assign bus.out_err   = m_err;
endmodule
